// File: rtl/keypad_scan.sv
// keypad_scan: scanner for a 4x4 hex keypad matrix.
// Drives one active-low column at a time and samples the active-low rows
// through a 2-flop synchronizer at the end of each column slot. The four
// column samples of one scan are reduced to NONE / SINGLE(code) / MULTI.
// A press or release is accepted after DEB identical consecutive scans.
// Every accepted press pulses key_strobe and shifts its hex code into data_out.
//
// Ports:
//   sl_clk     in   system clock
//   rst        in   asynchronous active-low reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous to sl_clk
//   clr        in   synchronous clear of data_out (takes priority over a shift)
//   col_out    out  [3:0] column drive, active-low one-hot
//   key_code   out  [3:0] code (4*row + col) of the last accepted key
//   key_valid  out  high while the accepted key is held
//   key_strobe out  one-cycle pulse per accepted press
//   data_out   out  [15:0] entry register, newest digit in [3:0]
//
// state   | meaning
// IDLE    | no key accepted; waiting for DEB stable SINGLE scans
// PRESSED | key accepted; waiting for DEB stable NONE scans
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB      = 4
) (
  input  logic        sl_clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  input  logic        clr,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_strobe,
  output logic [15:0] data_out
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB_L = 4'(DEB);

  typedef enum logic {IDLE, PRESSED} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    acc_code_q, acc_code_d;
  cls_t          prev_cls_q, prev_cls_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [3:0]    stab_q, stab_d;
  state_t        state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_strobe_q, key_strobe_d;
  logic [15:0]   data_q, data_d;

  logic       tick, scan_end;
  logic [2:0] row_cnt, hit_sum;
  logic [1:0] row_idx, scan_hits;
  logic [3:0] scan_code;
  cls_t       scan_cls;

  assign tick     = (div_q == DW'(SCAN_DIV - 1));
  assign scan_end = tick && (col_q == 2'd3);

  // Rows low in the current column sample; row_idx is the lowest such row.
  always_comb begin
    row_cnt = '0;
    row_idx = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!sync2_q[r]) begin
        row_cnt = row_cnt + 3'd1;
        row_idx = 2'(r);
      end
    end
  end

  // Hit count for the scan so far including this column, saturated at 2 (MULTI).
  assign hit_sum   = 3'(hits_q) + row_cnt;
  assign scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign scan_code = (hits_q == 2'd0 && row_cnt == 3'd1) ? {row_idx, col_q} : acc_code_q;
  assign scan_cls  = (scan_hits == 2'd0) ? CLS_NONE :
                     (scan_hits == 2'd1) ? CLS_SINGLE : CLS_MULTI;

  always_comb begin
    div_d       = tick ? '0 : div_q + DW'(1);
    col_d       = tick ? col_q + 2'd1 : col_q;
    hits_d      = hits_q;
    acc_code_d  = acc_code_q;
    prev_cls_d  = prev_cls_q;
    prev_code_d = prev_code_q;
    stab_d      = stab_q;
    if (tick) begin
      if (scan_end) begin
        hits_d      = '0;
        acc_code_d  = '0;
        prev_cls_d  = scan_cls;
        prev_code_d = scan_code;
        if (scan_cls == CLS_MULTI) begin
          stab_d = '0;
        end else if (scan_cls == prev_cls_q &&
                     (scan_cls != CLS_SINGLE || scan_code == prev_code_q)) begin
          stab_d = (stab_q >= DEB_L) ? DEB_L : stab_q + 4'd1;
        end else begin
          stab_d = 4'd1;
        end
      end else begin
        hits_d     = scan_hits;
        acc_code_d = scan_code;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    key_code_d   = key_code_q;
    key_valid_d  = key_valid_q;
    key_strobe_d = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (scan_cls == CLS_SINGLE && stab_d == DEB_L) begin
            state_d      = PRESSED;
            key_code_d   = scan_code;
            key_valid_d  = 1'b1;
            key_strobe_d = 1'b1;
          end
        end
        PRESSED: begin
          if (scan_cls == CLS_NONE && stab_d == DEB_L) begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (key_strobe_q) begin
      data_d = {data_q[11:0], key_code_q};
    end
  end

  always_ff @(posedge sl_clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      div_q        <= '0;
      col_q        <= '0;
      hits_q       <= '0;
      acc_code_q   <= '0;
      prev_cls_q   <= CLS_NONE;
      prev_code_q  <= '0;
      stab_q       <= '0;
      state_q      <= IDLE;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
      data_q       <= '0;
    end else begin
      sync1_q      <= row_in;
      sync2_q      <= sync1_q;
      div_q        <= div_d;
      col_q        <= col_d;
      hits_q       <= hits_d;
      acc_code_q   <= acc_code_d;
      prev_cls_q   <= prev_cls_d;
      prev_code_q  <= prev_code_d;
      stab_q       <= stab_d;
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_strobe_q <= key_strobe_d;
      data_q       <= data_d;
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_strobe = key_strobe_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan (SCAN_DIV=4, DEB=3).
// A keypad model turns the set of held keys into row levels from col_out.
// A scan-level reference model tracks expected outputs; a negedge process
// compares every output against it each cycle. Stimulus changes the held
// key set only right after scan boundaries.
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        sl_clk = 1'b0;
  logic        rst    = 1'b0;
  logic        clr    = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out, key_code;
  logic        key_valid, key_strobe;
  logic [15:0] data_out;
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int n_strobes = 0;

  always #5 sl_clk = ~sl_clk;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB(DEB)) dut (
    .sl_clk(sl_clk), .rst(rst), .row_in(row_in), .clr(clr),
    .col_out(col_out), .key_code(key_code), .key_valid(key_valid),
    .key_strobe(key_strobe), .data_out(data_out)
  );

  // Keypad: key 4*r+c pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at scan granularity.
  int          e;
  int          m_prev;   // 0..15 single code, 16 none, 17 multi
  int          m_cnt;
  bit          m_pressed;
  logic [3:0]  m_code;
  logic        m_valid, m_strobe;
  logic [15:0] m_data;
  logic [3:0]  m_col;

  always @(posedge sl_clk or negedge rst) begin
    if (!rst) begin
      e = 0; m_prev = 16; m_cnt = 0; m_pressed = 0;
      m_code = 0; m_valid = 0; m_strobe = 0; m_data = 0;
    end else begin
      int n, id;
      if (clr) m_data = 16'h0;
      else if (m_strobe) m_data = {m_data[11:0], m_code};
      e++;
      m_strobe = 0;
      if (e % SCAN == 0) begin
        n = $countones(keys);
        id = (n == 0) ? 16 : 17;
        if (n == 1)
          for (int i = 0; i < 16; i++) if (keys[i]) id = i;
        if (n >= 2) m_cnt = 0;
        else if (id == m_prev) m_cnt = (m_cnt + 1 > DEB) ? DEB : m_cnt + 1;
        else m_cnt = 1;
        m_prev = id;
        if (!m_pressed && n == 1 && m_cnt == DEB) begin
          m_pressed = 1; m_code = 4'(id); m_valid = 1; m_strobe = 1;
        end else if (m_pressed && n == 0 && m_cnt == DEB) begin
          m_pressed = 0; m_valid = 0;
        end
      end
    end
  end

  always @(negedge sl_clk) begin
    m_col = 4'hF;
    m_col[(e / SCAN_DIV) % 4] = 1'b0;
    chk("col_out", 16'(col_out), 16'(m_col));
    chk("key_strobe", 16'(key_strobe), 16'(m_strobe));
    chk("key_valid", 16'(key_valid), 16'(m_valid));
    chk("key_code", 16'(key_code), 16'(m_code));
    chk("data_out", data_out, m_data);
    if (key_strobe === 1'b1) n_strobes++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge sl_clk);
    #1;
  endtask

  task automatic scans(input int n);
    edges(n * SCAN);
  endtask

  initial begin
    // 1: reset mid-count, column rotation
    repeat (2) @(negedge sl_clk);
    rst = 1'b1;
    edges(6);
    rst = 1'b0;
    #1;
    chk("rst col_out", 16'(col_out), 16'h000E);
    chk("rst data_out", data_out, 16'h0000);
    chk("rst key_valid", 16'(key_valid), 16'h0);
    chk("rst key_strobe", 16'(key_strobe), 16'h0);
    @(negedge sl_clk);
    rst = 1'b1;
    edges(4);
    chk("col after 4", 16'(col_out), 16'h000D);
    edges(12);
    chk("col after 16", 16'(col_out), 16'h000E);

    // 2: key 9 held 6 scans, then released
    keys = 16'(1) << 9;
    scans(3);
    chk("k9 strobe", 16'(key_strobe), 16'h1);
    chk("k9 code", 16'(key_code), 16'h9);
    chk("k9 valid", 16'(key_valid), 16'h1);
    edges(1);
    chk("k9 data", data_out, 16'h0009);
    chk("k9 strobe gone", 16'(key_strobe), 16'h0);
    edges(SCAN - 1);
    scans(2);
    keys = '0;
    scans(3);
    chk("k9 released valid", 16'(key_valid), 16'h0);
    chk("k9 code kept", 16'(key_code), 16'h9);

    // 3: type 1..5
    for (int k = 1; k <= 5; k++) begin
      keys = 16'(1) << k;
      scans(3);
      edges(1);
      if (k == 4) chk("data 1234", data_out, 16'h1234);
      if (k == 5) chk("data 2345", data_out, 16'h2345);
      edges(SCAN - 1);
      keys = '0;
      scans(3);
    end

    // 4: key 6 bounces, then held
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? (16'(1) << 6) : 16'h0;
      scans(1);
    end
    keys = 16'(1) << 6;
    scans(3);
    chk("k6 strobe", 16'(key_strobe), 16'h1);
    edges(1);
    chk("k6 data", data_out, 16'h3456);
    edges(SCAN - 1);
    keys = '0;
    scans(3);

    // 5: keys 0 and F together, then F released
    keys = 16'h8001;
    scans(6);
    chk("multi valid", 16'(key_valid), 16'h0);
    keys = 16'h0001;
    scans(3);
    chk("k0 strobe", 16'(key_strobe), 16'h1);
    chk("k0 code", 16'(key_code), 16'h0);
    edges(1);
    chk("k0 data", data_out, 16'h4560);
    edges(SCAN - 1);
    keys = '0;
    scans(3);

    // 6: clr coincident with strobe, then reset during held press
    keys = 16'(1) << 10;
    scans(3);
    clr = 1'b1;
    chk("kA strobe", 16'(key_strobe), 16'h1);
    edges(1);
    clr = 1'b0;
    chk("clr wins data", data_out, 16'h0000);
    chk("kA code", 16'(key_code), 16'hA);
    chk("kA valid", 16'(key_valid), 16'h1);
    edges(5);
    rst = 1'b0;
    #2;
    chk("midpress rst valid", 16'(key_valid), 16'h0);
    chk("midpress rst col", 16'(col_out), 16'h000E);
    @(negedge sl_clk);
    rst = 1'b1;
    scans(2);
    chk("no early strobe", 16'(key_valid), 16'h0);
    scans(1);
    chk("kA re-strobe", 16'(key_strobe), 16'h1);
    edges(1);
    chk("kA data", data_out, 16'h000A);
    keys = '0;
    scans(3);

    chk("strobe count", 16'(n_strobes), 16'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the board's multiplexed 7-segment display driver: scans a 4x4 hex keypad matrix.
- Drives one active-low column at a time and samples the active-low rows.
- Debounces the result and emits one strobe per key press.
- Shifts each hex digit into a 16-bit entry register that feeds the register/display path.

Parameters:
- SCAN_DIV, 50000: sl_clk cycles each column stays driven. Must be >= 4.
- DEB, 4: consecutive identical full scans required to accept a press or a release. Range 2..15.

Ports:
- sl_clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows, active-low (pulled up); asynchronous to sl_clk.
- clr  input  1  synchronous clear of data_out.
- col_out  output  4  column drive, active-low one-hot.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  high while the accepted key is held.
- key_strobe  output  1  one-cycle pulse per accepted press.
- data_out  output  16  entry register; the newest digit is in [3:0].

Behaviour:
- Reset (rst low, asynchronous) sets:
  - col_out=4'b1110, key_code=0, key_valid=0, key_strobe=0, data_out=0;
  - state=IDLE, all counters=0, synchronizer flops=4'b1111.
- Reset mid-press discards all scan history. After release of rst, a held key is re-accepted only after DEB full scans.
- row_in passes through a 2-flop synchronizer. Only the synchronized value is used.
- Divider:
  - Counter runs 0..SCAN_DIV-1; tick = (count==SCAN_DIV-1).
  - On tick: sample the synchronized rows for the current column, then rotate col_out left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - A full scan is 4 ticks, ending on the column-3 tick.
- Key code: row r low while column c is driven gives code = 4*r + c (r, c in 0..3).
- Per-scan classification, accumulated over the 4 column samples:
  - NONE: no row low.
  - SINGLE(code): exactly one row/column hit.
  - MULTI: two or more hits.
- Stability counter, updated at scan end:
  - If the classification equals the previous scan's classification (for SINGLE, the code must also match), increment, saturating at DEB.
  - Otherwise load 1.
  - MULTI always loads 0 and never counts as stable.
- FSM, evaluated at scan end:
  - IDLE, SINGLE(k) stable count reaches DEB: go to PRESSED, key_code<=k, key_valid<=1, pulse key_strobe.
  - IDLE, any other condition: stay in IDLE.
  - PRESSED, NONE stable count reaches DEB: go to IDLE, key_valid<=0. key_code keeps its value.
  - PRESSED, SINGLE of a different code or MULTI: stay in PRESSED, no strobe. The key must be released first (no rollover).
- Latency:
  - key_strobe is high exactly one sl_clk cycle, the cycle after the tick that completes the DEB-th consistent scan.
  - key_code and key_valid update in that same cycle.
- Entry register:
  - On key_strobe: data_out <= {data_out[11:0], key_code}. The oldest digit drops off.
  - clr=1 sets data_out=0.
  - clr and key_strobe in the same cycle: clr wins, data_out=0. key_code and key_valid still update.
- Divider and column counters wrap freely.
- An output is never driven high-Z; exactly one col_out bit is low at all times.

Test Plan (SCAN_DIV=4, DEB=3):
1. Assert rst low mid-count, then release -> col_out=1110, data_out=0000, key_valid=0, key_strobe=0. Column sequence 1110, 1101, 1011, 0111 repeats every 16 clocks.
2. Pull row_in[2] low whenever col_out[1]=0, held 6 scans -> exactly one key_strobe at the end of scan 3; key_code=9, key_valid=1, data_out=0009. Release for 3 scans -> key_valid=0, key_code stays 9.
3. Type keys 1,2,3,4,5, each with a clean press and release -> data_out=1234 after the 4th key, 2345 after the 5th, five strobes total.
4. Bounce: key 6 pressed and released on alternating scans for 8 scans, then held 3 scans -> no strobe during the bounce, one strobe after the hold, data_out ends in 6.
5. Keys 0 and F held together for 6 scans -> no strobe, key_valid=0. Release F with 0 still held -> strobe with key_code=0 after 3 more scans.
6. Assert clr in the same cycle as the strobe for key A -> data_out=0000, key_code=A. Pull rst low during a held press, then release -> one new strobe after 3 scans.
